frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Per-frame controller sitting behind the ~60 Hz frame-rate pulse generator. Each qualified frame tick runs three phases in order (erase, update, draw) with a go/done handshake to each phase's unit, so screen memory is never erased and redrawn concurrently. It also provides a frame-rate divider, a pause input, a frame counter, and sticky overrun detection when a frame does not finish before the next tick.

## Interface

Parameters:
- DIV, default 1: process every DIV-th tick (DIV ≥ 1).
- FRAME_W, default 16: width of frame_count.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle frame pulse from the frame-rate timer.
- enable  in  1  high = run; low = pause, so no new frames launch.
- erase_done  in  1  one-cycle pulse from the erase unit.
- update_done  in  1  one-cycle pulse from the game-state update unit.
- draw_done  in  1  one-cycle pulse from the draw unit.
- clear_overrun  in  1  clears the overrun flag.
- erase_go  out  1  level; high for the whole ERASE phase.
- update_go  out  1  level; high for the whole UPDATE phase.
- draw_go  out  1  level; high for the whole DRAW phase.
- busy  out  1  high when state ≠ IDLE.
- frame_count  out  FRAME_W  number of completed frames; wraps.
- overrun  out  1  sticky; a qualified tick arrived while a frame was still in progress.

## Operation

States:
- IDLE: all go outputs low.
- ERASE: erase_go=1.
- UPDATE: update_go=1.
- DRAW: draw_go=1.

Only the go output of the current state is high. All go outputs, busy and overrun are registered.

Tick qualification:
- div_cnt is a counter of width clog2(DIV) with range 0..DIV-1.
- On tick with enable=1: if div_cnt==DIV-1, the tick is qualified ("qtick") and div_cnt←0; otherwise div_cnt increments.
- With DIV=1, every enabled tick is a qtick.
- With enable=0: ticks are ignored, div_cnt holds its value, and pending clears.

Transitions:
- IDLE→ERASE when enable=1 and (qtick or pending). Pending clears on this transition.
- ERASE→UPDATE on erase_done.
- UPDATE→DRAW on update_done.
- DRAW→IDLE on draw_done. frame_count increments on this transition (modulo 2^FRAME_W).
- A done input that does not match the current state is ignored.
- Dropping enable mid-frame does not abort the frame. The frame completes, then the FSM stays in IDLE.

Overrun and pending:
- A qtick while state ≠ IDLE sets pending (1-deep) and sets overrun.
- A qtick while pending is already set is dropped. overrun stays 1.
- Exception: a qtick in DRAW in the same cycle as draw_done sets pending but does not set overrun.
- clear_overrun clears overrun. If a clear and a set occur in the same cycle, set wins.

## Timing

- Reset (async, reset_n=0): state=IDLE, all go outputs=0, busy=0, frame_count=0, overrun=0, pending=0, div_cnt=0. Outputs drop immediately on assertion, including mid-frame.
- Launch latency: a qtick sampled in IDLE at edge T gives erase_go=1 and busy=1 after edge T.
- Phase handoff: a done sampled at edge D lowers the current go and raises the next go after edge D. No idle gap between phases.
- Completion: draw_done sampled at edge D gives draw_go=0, busy=0 and frame_count+1 after edge D.
- Pending launch: if pending is set, erase_go rises one cycle after returning to IDLE.
- Minimum frame length is 4 cycles: 1 in IDLE plus 1 per phase, with done returned in the first cycle of each phase.
- Done inputs and tick are synchronous to clock; no synchronizers are used.

## Test plan

- Reset then basic frame: DIV=1, enable=1. Pulse tick; answer each go with done 2 cycles later. Required: erase_go, then update_go, then draw_go each high 3 cycles with no gap; busy low after draw_done; frame_count=1; overrun=0.
- Divider: DIV=3, 7 ticks each spaced 100 cycles, phases completing quickly. Required: frames launch on ticks 3 and 6 only; frame_count=2.
- Overrun: DIV=1. Tick, hold update_done off, tick again during UPDATE, then tick a third time. Required: overrun=1; exactly one extra frame runs after the first; frame_count=2; the third tick is dropped.
- Boundary: tick in the same cycle as draw_done. Required: overrun stays 0; erase_go rises 2 cycles later. Also verify clear_overrun asserted in the same cycle as an overrun event leaves overrun=1.
- Pause and stray done: enable=0 mid-UPDATE. Required: the frame completes and no new frame launches on subsequent ticks. A draw_done pulsed during ERASE is ignored (state unchanged).
- Async reset mid-DRAW, plus wrap: assert reset_n=0 with draw_go=1. Required: all outputs return to reset values immediately. With FRAME_W=2, 5 frames give frame_count=1.

Source files
------------

// File: rtl/frame_sequencer.sv
// Per-frame controller: on each qualified frame tick it sequences the erase, update and
// draw units so screen memory is never erased and redrawn at the same time.
module frame_sequencer #(
    parameter int DIV     = 1,
    parameter int FRAME_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               enable,
    input  logic               erase_done,
    input  logic               update_done,
    input  logic               draw_done,
    input  logic               clear_overrun,
    output logic               erase_go,
    output logic               update_go,
    output logic               draw_go,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_count,
    output logic               overrun,
    output logic [1:0]         state_dbg
);

    // Handshake: each go is a level held for its whole phase; the unit answers with a
    // one-cycle done while its go is high. A done whose go is low is ignored.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERASE  = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAW   = 2'd3
    } state_t;

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] div_cnt;
    logic          pending;
    logic          qtick;
    logic          frame_end;
    logic          launch;
    logic          overrun_set;
    logic          erase_go_d;
    logic          update_go_d;
    logic          draw_go_d;

    assign qtick       = tick && enable && (div_cnt == DIV_LAST);
    assign frame_end   = (state == S_DRAW) && draw_done;
    assign launch      = (state == S_IDLE) && enable && (qtick || pending);
    // A tick landing on the very cycle the frame finishes is on time, not an overrun.
    assign overrun_set = qtick && (state != S_IDLE) && !frame_end;
    assign state_dbg   = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            erase_go  <= 1'b0;
            update_go <= 1'b0;
            draw_go   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            erase_go  <= erase_go_d;
            update_go <= update_go_d;
            draw_go   <= draw_go_d;
            busy      <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (launch)      state_next = S_ERASE;
            S_ERASE:  if (erase_done)  state_next = S_UPDATE;
            S_UPDATE: if (update_done) state_next = S_DRAW;
            S_DRAW:   if (draw_done)   state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    // Go levels are decoded from the next state so the registered copies line up with state.
    always_comb begin
        erase_go_d  = (state_next == S_ERASE);
        update_go_d = (state_next == S_UPDATE);
        draw_go_d   = (state_next == S_DRAW);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (tick && enable) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end

            if (!enable || launch) begin
                pending <= 1'b0;
            end else if (qtick && (state != S_IDLE)) begin
                pending <= 1'b1;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two instances (DIV=1/FRAME_W=2 and DIV=3/FRAME_W=16) checked
// every cycle against a phase-level reference model, plus directed scenario checks.
module tb_frame_sequencer;

    localparam int DIV_A = 1;
    localparam int FW_A  = 2;
    localparam int DIV_B = 3;
    localparam int FW_B  = 16;

    typedef struct {
        int phase;     // 0 idle, 1 erase, 2 update, 3 draw
        int age;       // cycles spent in the current phase
        int en_ticks;  // enabled ticks seen since reset
        bit pending;
        bit overrun;
        int frames;
    } model_t;

    typedef struct packed {
        logic tick;
        logic enable;
        logic erase_done;
        logic update_done;
        logic draw_done;
        logic clear_overrun;
    } in_t;

    logic clock = 1'b0;
    logic reset_n;
    in_t  ia;
    in_t  ib;

    logic            a_erase_go, a_update_go, a_draw_go, a_busy, a_overrun;
    logic [FW_A-1:0] a_frame_count;
    logic [1:0]      a_state_dbg;
    logic            b_erase_go, b_update_go, b_draw_go, b_busy, b_overrun;
    logic [FW_B-1:0] b_frame_count;
    logic [1:0]      b_state_dbg;

    frame_sequencer #(.DIV(DIV_A), .FRAME_W(FW_A)) dut_a (
        .clock(clock), .reset_n(reset_n), .tick(ia.tick), .enable(ia.enable),
        .erase_done(ia.erase_done), .update_done(ia.update_done), .draw_done(ia.draw_done),
        .clear_overrun(ia.clear_overrun), .erase_go(a_erase_go), .update_go(a_update_go),
        .draw_go(a_draw_go), .busy(a_busy), .frame_count(a_frame_count),
        .overrun(a_overrun), .state_dbg(a_state_dbg)
    );

    frame_sequencer #(.DIV(DIV_B), .FRAME_W(FW_B)) dut_b (
        .clock(clock), .reset_n(reset_n), .tick(ib.tick), .enable(ib.enable),
        .erase_done(ib.erase_done), .update_done(ib.update_done), .draw_done(ib.draw_done),
        .clear_overrun(ib.clear_overrun), .erase_go(b_erase_go), .update_go(b_update_go),
        .draw_go(b_draw_go), .busy(b_busy), .frame_count(b_frame_count),
        .overrun(b_overrun), .state_dbg(b_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    model_t ma;
    model_t mb;
    logic [FW_A-1:0] exp_q[$];
    logic prev_draw_a = 1'b0;

    logic tick_a = 0, tick_b = 0, clr_a = 0, clr_b = 0;
    logic en_a = 1, en_b = 1;
    logic [2:0] stray_a = '0;  // {erase, update, draw} extra done pulses
    bit rand_mode = 0;
    int lat_a[1:3];

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic model_t model_step(model_t m, in_t in, int div);
        model_t n = m;
        bit q = 0;
        bit finishing;
        if (in.enable && in.tick) begin
            n.en_ticks = m.en_ticks + 1;
            q = (n.en_ticks % div) == 0;
        end
        finishing = (m.phase == 3) && in.draw_done;

        if (m.phase == 0) n.phase = (in.enable && (q || m.pending)) ? 1 : 0;
        else if (m.phase == 1 && in.erase_done) n.phase = 2;
        else if (m.phase == 2 && in.update_done) n.phase = 3;
        else if (finishing) begin
            n.phase  = 0;
            n.frames = m.frames + 1;
        end
        n.age = (n.phase == m.phase) ? m.age + 1 : 0;

        if (!in.enable || m.phase == 0) n.pending = 0;
        else if (q) n.pending = 1;

        if (q && m.phase != 0 && !finishing) n.overrun = 1;
        else if (in.clear_overrun) n.overrun = 0;
        return n;
    endfunction

    // ---------------- scoreboard / compare ----------------
    task automatic compare_all();
        check_eq("a_go", 32'({a_erase_go, a_update_go, a_draw_go}),
                 32'({ma.phase == 1, ma.phase == 2, ma.phase == 3}));
        check_eq("a_busy", 32'(a_busy), 32'(ma.phase != 0));
        check_eq("a_count", 32'(a_frame_count), 32'(ma.frames % (1 << FW_A)));
        check_eq("a_overrun", 32'(a_overrun), 32'(ma.overrun));
        check_eq("b_go", 32'({b_erase_go, b_update_go, b_draw_go}),
                 32'({mb.phase == 1, mb.phase == 2, mb.phase == 3}));
        check_eq("b_busy", 32'(b_busy), 32'(mb.phase != 0));
        check_eq("b_count", 32'(b_frame_count), 32'(mb.frames % (1 << FW_B)));
        check_eq("b_overrun", 32'(b_overrun), 32'(mb.overrun));
        if (prev_draw_a && !a_draw_go && reset_n) begin
            check_eq("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("sb_frame", 32'(a_frame_count), 32'(exp_q.pop_front()));
        end
        prev_draw_a = a_draw_go;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        int old_frames;
        ia.tick = tick_a; ia.enable = en_a; ia.clear_overrun = clr_a;
        ib.tick = tick_b; ib.enable = en_b; ib.clear_overrun = clr_b;
        if (rand_mode) begin
            ia.erase_done  = $urandom_range(0, 3) == 0;
            ia.update_done = $urandom_range(0, 3) == 0;
            ia.draw_done   = $urandom_range(0, 3) == 0;
            ib.erase_done  = $urandom_range(0, 3) == 0;
            ib.update_done = $urandom_range(0, 3) == 0;
            ib.draw_done   = $urandom_range(0, 3) == 0;
        end else begin
            ia.erase_done  = (ma.phase == 1 && ma.age >= lat_a[1]) | stray_a[2];
            ia.update_done = (ma.phase == 2 && ma.age >= lat_a[2]) | stray_a[1];
            ia.draw_done   = (ma.phase == 3 && ma.age >= lat_a[3]) | stray_a[0];
            ib.erase_done  = (mb.phase == 1);
            ib.update_done = (mb.phase == 2);
            ib.draw_done   = (mb.phase == 3);
        end
        @(posedge clock);
        old_frames = ma.frames;
        ma = model_step(ma, ia, DIV_A);
        mb = model_step(mb, ib, DIV_B);
        if (ma.frames != old_frames) exp_q.push_back(ma.frames[FW_A-1:0]);
        #1;
        compare_all();
        tick_a = 0; tick_b = 0; clr_a = 0; clr_b = 0; stray_a = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ia = '0;
        ib = '0;
        tick_a = 0; tick_b = 0; clr_a = 0; clr_b = 0; stray_a = '0;
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        exp_q.delete();
        prev_draw_a = 1'b0;
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_until_a(input int ph, input int budget);
        int n = 0;
        while (ma.phase != ph && n < budget) begin
            cycle();
            n++;
        end
        check_eq("reach_phase", 32'(n < budget), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e_cnt, u_cnt, d_cnt, b_cnt;
        logic [6:0] launch_mask;

        // Reset then basic frame
        lat_a[1] = 2; lat_a[2] = 2; lat_a[3] = 2;
        do_reset();
        tick_a = 1;
        e_cnt = 0; u_cnt = 0; d_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            e_cnt += int'(a_erase_go);
            u_cnt += int'(a_update_go);
            d_cnt += int'(a_draw_go);
            b_cnt += int'(a_busy);
        end
        check_eq("basic_erase_len", 32'(e_cnt), 32'd3);
        check_eq("basic_update_len", 32'(u_cnt), 32'd3);
        check_eq("basic_draw_len", 32'(d_cnt), 32'd3);
        check_eq("basic_busy_len", 32'(b_cnt), 32'd9);
        check_eq("basic_count", 32'(a_frame_count), 32'd1);
        check_eq("basic_overrun", 32'(a_overrun), 32'd0);

        // Divider on DIV=3 instance
        do_reset();
        launch_mask = '0;
        for (int t = 0; t < 7; t++) begin
            tick_b = 1;
            cycle();
            launch_mask[t] = b_erase_go;
            repeat (99) cycle();
        end
        check_eq("div_launch_mask", 32'(launch_mask), 32'b0100100);
        check_eq("div_count", 32'(b_frame_count), 32'd2);

        // Overrun: second tick during UPDATE, third tick dropped
        do_reset();
        lat_a[1] = 1; lat_a[2] = 1000; lat_a[3] = 1;
        tick_a = 1;
        cycle();
        run_until_a(2, 10);
        cycle();
        tick_a = 1;
        cycle();
        check_eq("ovr_set", 32'(a_overrun), 32'd1);
        cycle();
        cycle();
        tick_a = 1;
        cycle();
        lat_a[2] = 1;
        repeat (30) cycle();
        check_eq("ovr_count", 32'(a_frame_count), 32'd2);
        check_eq("ovr_sticky", 32'(a_overrun), 32'd1);
        check_eq("ovr_idle", 32'(a_busy), 32'd0);

        // Boundary: tick coincident with draw_done; clear vs set
        do_reset();
        lat_a[1] = 0; lat_a[2] = 0; lat_a[3] = 4;
        tick_a = 1;
        cycle();
        run_until_a(3, 10);
        for (int k = 0; k < 10 && ma.age < 4; k++) cycle();
        tick_a = 1;
        cycle();
        check_eq("bnd_no_overrun", 32'(a_overrun), 32'd0);
        check_eq("bnd_idle_gap", 32'(a_erase_go), 32'd0);
        cycle();
        check_eq("bnd_relaunch", 32'(a_erase_go), 32'd1);
        tick_a = 1;
        clr_a = 1;
        cycle();
        check_eq("clr_vs_set", 32'(a_overrun), 32'd1);
        clr_a = 1;
        cycle();
        check_eq("clr_alone", 32'(a_overrun), 32'd0);
        repeat (20) cycle();

        // Pause mid-UPDATE, then a stray draw_done during ERASE
        do_reset();
        lat_a[1] = 1; lat_a[2] = 3; lat_a[3] = 1;
        tick_a = 1;
        cycle();
        run_until_a(2, 10);
        en_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick_a = 1;
            cycle();
            cycle();
        end
        check_eq("pause_count", 32'(a_frame_count), 32'd1);
        check_eq("pause_idle", 32'(a_busy), 32'd0);
        en_a = 1;
        lat_a[1] = 1000;
        tick_a = 1;
        cycle();
        cycle();
        stray_a = 3'b001;
        cycle();
        check_eq("stray_erase_held", 32'(a_erase_go), 32'd1);
        check_eq("stray_no_draw", 32'(a_draw_go), 32'd0);
        lat_a[1] = 0;
        repeat (12) cycle();

        // Async reset mid-DRAW, then counter wrap with FRAME_W=2
        do_reset();
        lat_a[1] = 0; lat_a[2] = 0; lat_a[3] = 1000;
        tick_a = 1;
        cycle();
        run_until_a(3, 10);
        cycle();
        check_eq("pre_rst_draw", 32'(a_draw_go), 32'd1);
        #2;
        do_reset();
        check_eq("rst_draw", 32'(a_draw_go), 32'd0);
        lat_a[3] = 0;
        for (int f = 0; f < 5; f++) begin
            tick_a = 1;
            cycle();
            run_until_a(0, 20);
        end
        check_eq("wrap_count", 32'(a_frame_count), 32'd1);

        // Randomized traffic on both instances
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick_a = $urandom_range(0, 5) == 0;
            tick_b = $urandom_range(0, 3) == 0;
            en_a   = $urandom_range(0, 15) != 0;
            en_b   = $urandom_range(0, 15) != 0;
            clr_a  = $urandom_range(0, 15) == 0;
            clr_b  = $urandom_range(0, 15) == 0;
            cycle();
        end
        rand_mode = 0;
        en_a = 1;
        en_b = 1;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
